// File: rtl/speed_estimator_if.sv
// Bus between the encoder-side sampler and the speed consumers: control and angles in, averaged omega out.
interface speed_estimator_if #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned ANGLE_W  = 32,
    parameter int unsigned PERIOD_W = 25
);
    logic                     enable;
    logic [PERIOD_W-1:0]      period;
    logic [NCH*ANGLE_W-1:0]   angle;
    logic [NCH*ANGLE_W-1:0]   omega;
    logic                     omega_valid;
    logic                     primed;

    modport master (
        output enable, period, angle,
        input  omega, omega_valid, primed
    );

    modport slave (
        input  enable, period, angle,
        output omega, omega_valid, primed
    );
endinterface

// File: rtl/speed_estimator.sv
// Multi-channel angle-difference speed estimator: periodic sampling, wrap-safe signed delta,
// power-of-two moving average, registered omega with a one-cycle valid strobe.
module speed_estimator #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned ANGLE_W  = 32,
    parameter int unsigned PERIOD_W = 25,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    speed_estimator_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = ANGLE_W + AVG_LOG2;
    localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;

    logic [PERIOD_W-1:0]        r_count;
    logic                       r_prev_ok;
    logic                       r_s1_vld;
    logic                       r_s2_vld;
    logic [ANGLE_W-1:0]         r_prev  [NCH];
    logic signed [ANGLE_W-1:0]  r_delta [NCH];
    logic signed [ANGLE_W-1:0]  r_hist  [NCH][DEPTH];
    logic signed [SUM_W-1:0]    r_sum   [NCH];
    logic [PTR_W-1:0]           r_ptr;
    logic [FILL_W-1:0]          r_fill;
    logic                       r_primed;
    logic [NCH*ANGLE_W-1:0]     r_omega;
    logic                       r_omega_vld;

    logic [PERIOD_W-1:0]        w_last;
    logic                       w_tick;

    // Period 0 behaves as 1; ">=" lets a shrunken period tick on the next enabled edge.
    always_comb begin
        w_last = (bus.period == '0) ? '0 : bus.period - PERIOD_W'(1);
        w_tick = bus.enable && (r_count >= w_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_prev_ok   <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_primed    <= 1'b0;
            r_omega     <= '0;
            r_omega_vld <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_prev[c]  <= '0;
                r_delta[c] <= '0;
                r_sum[c]   <= '0;
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    r_hist[c][d] <= '0;
                end
            end
        end else begin
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_omega_vld <= 1'b0;

            if (w_tick) begin
                r_count <= '0;
            end else if (bus.enable) begin
                r_count <= r_count + PERIOD_W'(1);
            end

            // Stage 1: the first tick after reset only seeds prev.
            if (w_tick) begin
                r_prev_ok <= 1'b1;
                r_s1_vld  <= r_prev_ok;
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_prev[c]  <= bus.angle[c*ANGLE_W +: ANGLE_W];
                    r_delta[c] <= bus.angle[c*ANGLE_W +: ANGLE_W] - r_prev[c];
                end
            end

            // Stage 2: running window sum; unfilled slots are still zero from reset.
            if (r_s1_vld) begin
                r_s2_vld <= 1'b1;
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_sum[c]         <= r_sum[c] + SUM_W'(r_delta[c]) - SUM_W'(r_hist[c][r_ptr]);
                    r_hist[c][r_ptr] <= r_delta[c];
                end
                r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
                if (r_fill != FILL_W'(DEPTH)) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
                if (r_fill == FILL_W'(DEPTH - 1)) begin
                    r_primed <= 1'b1;
                end
            end

            // Stage 3: floor-average and publish all channels together.
            if (r_s2_vld && r_primed) begin
                r_omega_vld <= 1'b1;
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_omega[c*ANGLE_W +: ANGLE_W] <= ANGLE_W'(r_sum[c] >>> AVG_LOG2);
                end
            end
        end
    end

    assign bus.omega       = r_omega;
    assign bus.omega_valid = r_omega_vld;
    assign bus.primed      = r_primed;
endmodule

// File: doc/speed_estimator.md
Name: speed_estimator

Overview:
- Multi-channel successor to the single-channel angle-difference speed block.
- Samples NCH encoder angle accumulators every `period` clocks and forms a signed per-sample delta for each channel. Wrap-around is handled modulo 2^ANGLE_W.
- Smooths each delta with a power-of-two moving average and presents omega with a one-cycle valid strobe.
- Sits between the encoder counters and the motor speed controllers.

Parameters:
- NCH, 2: number of independent angle channels.
- ANGLE_W, 32: angle and omega width in bits.
- PERIOD_W, 25: width of the runtime sample-period input.
- AVG_LOG2, 2: log2 of the moving-average depth (depth = 2^AVG_LOG2); AVG_LOG2 = 0 means no averaging.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when low, the period counter freezes and no samples are taken.
- period, input, PERIOD_W: sample period in clocks; a value of 0 is treated as 1.
- angle, input, NCH*ANGLE_W: packed unsigned angles; channel i occupies bits [i*ANGLE_W +: ANGLE_W].
- omega, output, NCH*ANGLE_W: packed two's-complement averaged speed in angle units per sample period.
- omega_valid, output, 1: one-cycle strobe; all channels of omega are updated together.
- primed, output, 1: high once the averaging window holds DEPTH real deltas.

Behaviour:
- Reset (synchronous, takes effect at any time including mid-window) clears:
  - counter to 0;
  - all history entries, sums, prev-angle registers and the fill count;
  - omega to 0, omega_valid to 0, primed to 0.
- Tick counter:
  - counts 0..P-1, where P = max(period, 1), then wraps to 0;
  - a tick occurs on the edge where enable = 1 and count == P-1;
  - `period` is read every cycle; if count >= P-1 after a change, the next enabled edge ticks and clears count;
  - enable = 0 holds count and suppresses ticks; it does not clear history.
- Stage 1 (tick edge), per channel:
  - capture angle into cur;
  - delta = cur - prev, computed in ANGLE_W bits modulo 2^ANGLE_W and interpreted as signed, so 0xFFFFFFF0 -> 0x00000010 yields +32;
  - prev <= cur.
  - The first tick after reset only loads prev; it produces no delta and no stage-2 activity.
- Stage 2 (next edge), per channel:
  - ring buffer of DEPTH signed deltas with a shared write pointer;
  - sum (ANGLE_W + AVG_LOG2 bits, signed) <= sum + delta - oldest entry; oldest is 0 while filling;
  - overwrite the oldest entry and advance the pointer, wrapping at DEPTH;
  - fill count saturates at DEPTH; primed goes high on the edge where it reaches DEPTH.
- Stage 3 (next edge):
  - if primed (including the edge that just set it), omega_i <= sum_i >>> AVG_LOG2 (arithmetic shift, rounds toward -infinity, truncated to ANGLE_W bits) and omega_valid <= 1;
  - otherwise omega holds and omega_valid stays 0;
  - omega_valid is 0 on all non-update cycles.
- Latency: omega_valid is high in the cycle starting 2 edges after the sampling tick edge.
- First valid output occurs on the (DEPTH+1)-th tick after reset.
- P = 1 with enable held high gives a tick every cycle; the pipeline sustains this at full rate.
- Throughput: one result per tick.
- Overflow: the sum cannot overflow, because it is sized for DEPTH full-scale deltas.

Test Plan:
- Reset: hold reset 3 cycles with random angle -> omega = 0, omega_valid = 0, primed = 0; no valid strobe until tick 5 (DEPTH = 4, period = 4).
- Ramp: ch0 angle += 3 per clk, period = 4 -> 4 valid-free ticks, then omega_valid on tick 5 with omega0 = 12; valid repeats every 4 clocks, always 2 clocks after its tick.
- Wrap: ch1 samples 0xFFFFFFA0, 0xFFFFFFC0, 0xFFFFFFE0, 0x00000000, 0x00000020 -> omega1 = 32 (0x00000020) at first valid, with no glitch across the wrap.
- Negative and rounding: ch0 deltas -5,-5,-5,-5 -> omega0 = 0xFFFFFFFB. Then deltas 0,0,0,-1 -> omega0 = 0xFFFFFFFF (-1) and a later window of 0,0,0,8 -> omega0 = 2.
- Enable and period=0: enable = 0 for 10 clocks mid-stream -> no strobes, counter frozen, history kept. Then period = 0 with enable = 1 -> omega_valid high every cycle.
- Reset mid-operation: assert reset while primed = 1 -> primed = 0 and omega = 0 next edge; after release the full (DEPTH+1)-tick priming repeats before the next strobe.
